// File: rtl/flag_stack_reg_pkg.sv
// Shared constants and types for the condition-flag register and its save stack.
package flag_pkg;

    // Bit positions of the architectural flags inside the flag word.
    localparam int FLAG_Z = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 2;

    // Default geometry: three flags, four saved contexts.
    localparam int DEFAULT_WIDTH = 3;
    localparam int DEFAULT_DEPTH = 4;

    // Flag word at the default width.
    typedef logic [DEFAULT_WIDTH-1:0] flags_t;

endpackage : flag_pkg

// File: rtl/flag_stack_reg_if.sv
// Control/status bundle between the ALU/branch side (master) and the flag register (slave).
interface flag_stack_reg_if
    import flag_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] WriteInput;
    logic [WIDTH-1:0] WriteMask;
    logic             WriteEnable;
    logic             ReadEnable;
    logic             Push;
    logic             Pop;
    logic             Full;
    logic             Empty;
    logic [CW-1:0]    Count;
    logic             Error;

    modport master (
        output WriteInput, WriteMask, WriteEnable, ReadEnable, Push, Pop,
        input  Full, Empty, Count, Error
    );

    modport slave (
        input  WriteInput, WriteMask, WriteEnable, ReadEnable, Push, Pop,
        output Full, Empty, Count, Error
    );

endinterface : flag_stack_reg_if

// File: rtl/flag_stack_reg_save_stack.sv
// Linear LIFO of flag words used to save/restore flag context.
// Supports push, pop and a same-cycle swap of the top entry; overflow and
// underflow attempts are dropped and latch a sticky error.
module flag_save_stack
    import flag_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_save,
    output logic [WIDTH-1:0] o_top,
    output logic             o_restore,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_error
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic             r_error;

    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count_m1;
    logic [AW-1:0]    w_top_addr;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_addr;
    logic [CW-1:0]    w_count_next;
    logic             w_err_set;
    logic             w_restore;

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_count_m1 = r_count - CW'(1);
    assign w_top_addr = w_count_m1[AW-1:0];

    // Decode push/pop/swap into a memory write, a count update and error detection.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_wr_en      = 1'b0;
        w_wr_addr    = '0;
        w_count_next = r_count;
        w_err_set    = 1'b0;
        w_restore    = 1'b0;
        unique case ({i_push, i_pop})
            2'b11: begin
                // Swap: old flags replace the top entry, top is restored.
                if (w_empty) begin
                    w_err_set = 1'b1;
                end else begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = w_top_addr;
                    w_restore = 1'b1;
                end
            end
            2'b10: begin
                if (w_full) begin
                    w_err_set = 1'b1;
                end else begin
                    w_wr_en      = 1'b1;
                    w_wr_addr    = r_count[AW-1:0];
                    w_count_next = r_count + CW'(1);
                end
            end
            2'b01: begin
                if (w_empty) begin
                    w_err_set = 1'b1;
                end else begin
                    w_restore    = 1'b1;
                    w_count_next = w_count_m1;
                end
            end
            default: begin
            end
        endcase
    end

    // Occupancy count and sticky error; both cleared only by reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst) begin
            r_count <= '0;
            r_error <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_error <= r_error | w_err_set;
        end
    end

    // Stack storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; entries above the count are never read as valid data.
        if (rst && w_wr_en) begin
            r_mem[w_wr_addr] <= i_save;
        end
    end

    assign o_top     = r_mem[w_top_addr];
    assign o_restore = w_restore;
    assign o_count   = r_count;
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_error   = r_error;

endmodule : flag_save_stack

// File: rtl/flag_stack_reg.sv
// Condition-flag register with per-bit masked write, tri-state read port and
// a save/restore stack. Restored values are applied first and the masked
// write is merged on top, so written bits always win.
module flag_stack_reg
    import flag_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    flag_stack_reg_if.slave       bus,
    // Shared read bus towards the branch unit; released to Z when not enabled.
    output wire logic [WIDTH-1:0] ReadOutput
);

    logic [WIDTH-1:0] r_flags;
    logic [WIDTH-1:0] w_top;
    logic             w_restore;
    logic [WIDTH-1:0] w_flags_base;
    logic [WIDTH-1:0] w_flags_next;

    // The stack always saves the flags as they were before this edge's write.
    flag_save_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .i_push    (bus.Push),
        .i_pop     (bus.Pop),
        .i_save    (r_flags),
        .o_top     (w_top),
        .o_restore (w_restore),
        .o_count   (bus.Count),
        .o_full    (bus.Full),
        .o_empty   (bus.Empty),
        .o_error   (bus.Error)
    );

    // Next flag value: restored top (if a pop is accepted), then masked write over it.
    always_comb begin
        w_flags_base = w_restore ? w_top : r_flags;
        w_flags_next = w_flags_base;
        if (bus.WriteEnable) begin
            w_flags_next = (w_flags_base & ~bus.WriteMask) | (bus.WriteInput & bus.WriteMask);
        end
    end

    // Flag register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_flags <= '0;
        end else begin
            r_flags <= w_flags_next;
        end
    end

    assign ReadOutput = bus.ReadEnable ? r_flags : {WIDTH{1'bz}};

endmodule : flag_stack_reg

// File: tb/tb_flag_stack_reg.sv
// Scoreboard bench for flag_stack_reg: directed scenarios then random traffic,
// compared against a queue-based behavioural model.
module tb_flag_stack_reg;
    import flag_pkg::*;

    localparam int W  = 3;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    typedef struct {
        logic [W-1:0]  rd;
        logic [CW-1:0] cnt;
        logic          full;
        logic          empty;
        logic          err;
    } exp_t;

    logic         clk;
    logic         rst;
    wire [W-1:0]  read_output;

    flag_stack_reg_if #(.WIDTH(W), .DEPTH(D)) bus ();

    flag_stack_reg #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .ReadOutput (read_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [W-1:0] m_flags;
    logic [W-1:0] m_stack[$];
    bit           m_err;
    exp_t         sb[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus and record what the DUT must show after the edge.
    task automatic step(input bit rst_n, input logic [W-1:0] wi, input logic [W-1:0] wm,
                        input bit we, input bit re, input bit push, input bit pop);
        logic [W-1:0] base;
        exp_t e;
        @(negedge clk);
        rst             = rst_n;
        bus.WriteInput  = wi;
        bus.WriteMask   = wm;
        bus.WriteEnable = we;
        bus.ReadEnable  = re;
        bus.Push        = push;
        bus.Pop         = pop;
        if (!rst_n) begin
            m_flags = '0;
            m_stack.delete();
            m_err   = 1'b0;
        end else begin
            base = m_flags;
            if (push && pop) begin
                if (m_stack.size() == 0) m_err = 1'b1;
                else begin
                    base = m_stack[$];
                    m_stack[$] = m_flags;
                end
            end else if (push) begin
                if (m_stack.size() == D) m_err = 1'b1;
                else m_stack.push_back(m_flags);
            end else if (pop) begin
                if (m_stack.size() == 0) m_err = 1'b1;
                else base = m_stack.pop_back();
            end
            for (int i = 0; i < W; i++) begin
                if (we && wm[i]) base[i] = wi[i];
            end
            m_flags = base;
        end
        e.rd    = re ? m_flags : {W{1'bz}};
        e.cnt   = CW'(m_stack.size());
        e.full  = (m_stack.size() == D);
        e.empty = (m_stack.size() == 0);
        e.err   = m_err;
        sb.push_back(e);
    endtask

    // Monitor: after every edge compare the DUT against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("ReadOutput", 32'(read_output), 32'(e.rd));
            check("Count",      32'(bus.Count),   32'(e.cnt));
            check("Full",       32'(bus.Full),    32'(e.full));
            check("Empty",      32'(bus.Empty),   32'(e.empty));
            check("Error",      32'(bus.Error),   32'(e.err));
        end
    end

    initial begin
        int wait_cycles;
        rst = 1'b1;
        bus.WriteInput = '0; bus.WriteMask = '0; bus.WriteEnable = 1'b0;
        bus.ReadEnable = 1'b0; bus.Push = 1'b0; bus.Pop = 1'b0;
        m_flags = '0; m_err = 1'b0;

        // Reset, then release read bus.
        step(0, 3'b000, 3'b000, 0, 1, 0, 0);
        step(1, 3'b000, 3'b000, 0, 0, 0, 0);
        // Masked writes.
        step(1, 3'b111, 3'b111, 1, 1, 0, 0);
        step(1, 3'b000, 3'b010, 1, 1, 0, 0);
        step(1, 3'b000, 3'b000, 0, 1, 0, 0);
        // Push with same-cycle write, then pop.
        step(1, 3'b011, 3'b111, 1, 1, 1, 0);
        step(1, 3'b000, 3'b000, 0, 1, 0, 1);
        // Fill, overflow, drain.
        for (int v = 1; v <= D; v++) begin
            step(1, W'(v), 3'b111, 1, 1, 0, 0);
            step(1, 3'b000, 3'b000, 0, 1, 1, 0);
        end
        step(1, 3'b000, 3'b000, 0, 1, 1, 0);
        for (int k = 0; k < D; k++) step(1, 3'b000, 3'b000, 0, 1, 0, 1);
        // Underflow keeps flags, error sticky until reset.
        step(0, 3'b000, 3'b000, 0, 1, 0, 0);
        step(1, 3'b110, 3'b111, 1, 1, 0, 0);
        step(1, 3'b000, 3'b000, 0, 1, 0, 1);
        step(1, 3'b000, 3'b000, 0, 1, 0, 0);
        step(1, 3'b000, 3'b000, 0, 0, 1, 1);
        step(0, 3'b000, 3'b000, 0, 1, 0, 0);
        // Swap.
        step(1, 3'b110, 3'b111, 1, 1, 0, 0);
        step(1, 3'b000, 3'b000, 0, 1, 1, 0);
        step(1, 3'b001, 3'b111, 1, 1, 0, 0);
        step(1, 3'b000, 3'b000, 0, 1, 1, 1);
        step(1, 3'b000, 3'b000, 0, 1, 0, 1);
        step(0, 3'b000, 3'b000, 0, 1, 0, 0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) != 0),
                 W'($urandom), W'($urandom),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 9) < 4));
        end

        wait_cycles = 0;
        while (sb.size() != 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_flag_stack_reg
